// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   uart_state_t               frame-level state (IDLE/START/DATA/PARITY/STOP)
//   UART_CLKS_PER_BIT_DEFAULT  50 MHz system clock / 115200 baud
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: restartable bit-period counter with a terminal-count pulse.
//   clk    system clock, rising edge
//   rst    synchronous active-high reset (count = 0)
//   clear  hold the count at 0 while high
//   limit  terminal count; the counter wraps to 0 after reaching it
//   tick   high for the cycle in which count == limit
module uart_baud_cnt #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  always_comb tick = (count == limit);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver for the BLDC command link (8N1, optional even parity).
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   RX          asynchronous serial line, idle high
//   RX_DATA     last correctly received byte, held until the next good frame
//   RX_VALID    one-cycle pulse when RX_DATA has just been updated
//   FRAME_ERR   one-cycle pulse when the stop bit was sampled low
//   PARITY_ERR  one-cycle pulse on even-parity mismatch (0 unless parity built in)
//   BUSY        high from start-bit detection until the frame ends
// Build option: define UART_RX_PARITY_EN to insert an even-parity bit after data.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 BUSY
);

  localparam int unsigned     CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF_LIMIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LIMIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_BIT   = 4'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  uart_state_t          state;
  logic                 armed;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0]        limit;
  logic                 cnt_clear;
  logic                 tick;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // The counter is held at zero in IDLE and wraps on every tick, so it
  // restarts on each state change and each bit sample.
  always_comb begin
    limit     = (state == ST_START) ? HALF_LIMIT : BIT_LIMIT;
    cnt_clear = (state == ST_IDLE);
  end

  uart_baud_cnt #(
    .WIDTH(CW)
  ) u_baud (
    .clk  (CLK),
    .rst  (RST),
    .clear(cnt_clear),
    .limit(limit),
    .tick (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      armed      <= 1'b1;
      bit_idx    <= '0;
      shreg      <= '0;
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      FRAME_ERR  <= 1'b0;
      PARITY_ERR <= 1'b0;
      BUSY       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      RX_VALID   <= 1'b0;
      FRAME_ERR  <= 1'b0;
      PARITY_ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          // After a framing error the line must be seen high again before a
          // new start is accepted, so a held break is not read as frames.
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= ST_START;
            BUSY  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            parity_bad <= rx_s ^ (^shreg);
            state      <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            if (!rx_s) begin
              FRAME_ERR <= 1'b1;
              armed     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            end else if (parity_bad) begin
              PARITY_ERR <= 1'b1;
`endif
            end else begin
              RX_DATA  <= shreg;
              RX_VALID <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
